neander_ctrl: RTL and testbench
===============================

# neander_ctrl

Control unit for the 8-bit Neander accumulator CPU. It sequences the fetch/decode/execute cycle by driving load strobes and mux selects for the datapath registers: PC (a load-only register with no internal increment, fed through an external PC+1/RDM mux), REM, RDM, RI, AC and the NZ flags. It also drives ALU operation selects and memory read/write strobes. It sits beside the datapath and is the only block that issues `pc_load`.

## Interface
Parameters:
- `HALT_ON_UNDEF`, default 0: 0 = undefined opcodes execute as NOP; 1 = undefined opcodes halt the CPU.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `opcode` in 4: RI[7:4], registered in RI.
- `flag_n` in 1: registered N flag.
- `flag_z` in 1: registered Z flag.
- `rem_load` out 1: load REM.
- `rem_sel` out 1: REM source; 0 = PC, 1 = RDM.
- `rdm_load` out 1: load RDM.
- `rdm_sel` out 1: RDM source; 0 = memory data, 1 = AC.
- `ri_load` out 1: load RI from RDM.
- `pc_load` out 1: load PC.
- `pc_sel` out 1: PC source; 0 = PC+1, 1 = RDM.
- `ac_load` out 1: load AC from the ALU.
- `nz_load` out 1: load the N and Z flags from the ALU result.
- `ula_sel` out 3: ALU operation.
  - 000 ADD
  - 001 OR
  - 010 AND
  - 011 NOT X
  - 100 PASS Y (LDA)
- `mem_rd` out 1: memory read at address REM; memory is combinational-read.
- `mem_wr` out 1: write RDM to memory at address REM.
- `halted` out 1: high in HALT.

## Operation
- Opcodes:
  - NOP 0x0, STA 0x1, LDA 0x2, ADD 0x3, OR 0x4, AND 0x5, NOT 0x6.
  - JMP 0x8, JN 0x9, JZ 0xA, HLT 0xF.
  - 0x7, 0xB–0xE are undefined.
- States are T0–T7 plus HALT (4-bit encoding).
- Strobes not listed for a state are 0; selects default to 0 (`ula_sel` = 000).
- T0: `rem_sel`=0, `rem_load`. Next state T1.
- T1: `mem_rd`, `rdm_load`, `pc_sel`=0, `pc_load`. Next state T2.
- T2: `ri_load`. Next state T3.
- T3 decodes `opcode`:
  - NOP, or undefined with `HALT_ON_UNDEF`=0: no strobes. Next state T0.
  - NOT: `ula_sel`=011, `ac_load`, `nz_load`. Next state T0.
  - HLT, or undefined with `HALT_ON_UNDEF`=1: next state HALT.
  - JN with `flag_n`=0, or JZ with `flag_z`=0: `pc_sel`=0, `pc_load` (skip operand). Next state T0.
  - Otherwise: `rem_sel`=0, `rem_load`. Next state T4.
- T4: `mem_rd`, `rdm_load`. For STA/LDA/ADD/OR/AND also `pc_sel`=0, `pc_load`. Next state T5.
- T5:
  - JMP/JN/JZ: `pc_sel`=1, `pc_load`. Next state T0.
  - Otherwise: `rem_sel`=1, `rem_load`. Next state T6.
- T6:
  - STA: `rdm_sel`=1, `rdm_load`.
  - Others: `mem_rd`, `rdm_load`.
  - Next state T7.
- T7:
  - STA: `mem_wr`.
  - LDA/ADD/OR/AND: `ula_sel` per opcode, `ac_load`, `nz_load`.
  - Next state T0.
- HALT: all strobes 0 and `halted`=1. Leaves HALT only on `rst`.
- Outputs are combinational from state, `opcode` and flags. All three inputs are registered, so the outputs are glitch-safe within a cycle.
- Instruction cycle counts:
  - NOP, NOT, not-taken JN/JZ: 4.
  - JMP, taken JN/JZ: 6.
  - STA, LDA, ADD, OR, AND: 8.
  - HLT: 4, then HALT.

## Timing
- While `rst`=1: state = T0 immediately (asynchronous). All strobes are 0, `halted`=0.
  - Note: T0's `rem_load` is suppressed while `rst` is high. The datapath registers are also in reset, so PC = 0.
- After `rst` falls, the first rising edge executes T0; the first fetch is from address 0x00.
- Reset mid-instruction (any state, including T6/T7 of STA) aborts immediately. `mem_wr` must never assert after `rst` rises.
- The flag decision is taken in T3 using the flags as they stand at that edge. An instruction's own NZ update, issued in T7/T3, is visible to the next instruction's T3.
- The PC increments exactly once per fetch (T1) and once per operand (T4, or T3 when a conditional jump is not taken). PC wraps 0xFF→0x00 in the datapath; the controller takes no special action.
- `mem_wr` is a single-cycle pulse.

## Test plan
- Reset then NOP at 0x00 → `rem_load` in cycle 1, `mem_rd`+`pc_load` in cycle 2, `ri_load` in cycle 3, idle in cycle 4; next fetch begins in cycle 5 (PC=0x01).
- Program `LDA 0x80; ADD 0x81; STA 0x82; HLT` with mem[0x80]=0x05, mem[0x81]=0x03 → mem[0x82]=0x08, `halted`=1 after 28 cycles, PC=0x07.
- `JN 0x20` with `flag_n`=0 → 4 cycles, PC advances by 2. With `flag_n`=1 → 6 cycles, PC=0x20. Repeat both cases for JZ/`flag_z`.
- NOT with AC=0x00 → AC=0xFF and N=1 after 4 cycles. Then an undefined opcode 0xB with `HALT_ON_UNDEF`=0 → acts as NOP. With `HALT_ON_UNDEF`=1 → `halted`=1.
- Assert `rst` asynchronously during T7 of STA → `mem_wr` never asserts; state goes to T0, all outputs 0; the fetch restarts at 0x00 after release.
- HLT reached → all strobes stay 0 for ≥100 cycles regardless of `opcode`/flag changes, until `rst`.

Source files
------------

// File: rtl/neander_ctrl_if.sv
// Control bundle between the Neander controller and its datapath.
// The controller is the master: it reads RI[7:4] and the NZ flags, and drives every strobe and select.
interface neander_ctrl_if;
  logic [3:0] opcode;
  logic       flag_n;
  logic       flag_z;
  logic       rem_load;
  logic       rem_sel;
  logic       rdm_load;
  logic       rdm_sel;
  logic       ri_load;
  logic       pc_load;
  logic       pc_sel;
  logic       ac_load;
  logic       nz_load;
  logic [2:0] ula_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;

  modport master (
    input  opcode, flag_n, flag_z,
    output rem_load, rem_sel, rdm_load, rdm_sel, ri_load, pc_load, pc_sel,
           ac_load, nz_load, ula_sel, mem_rd, mem_wr, halted
  );

  modport slave (
    output opcode, flag_n, flag_z,
    input  rem_load, rem_sel, rdm_load, rdm_sel, ri_load, pc_load, pc_sel,
           ac_load, nz_load, ula_sel, mem_rd, mem_wr, halted
  );
endinterface

// File: rtl/neander_ctrl.sv
// Neander control unit: sequences fetch/decode/execute through T0..T7 and drives the datapath strobes.
// Outputs are decoded from state, opcode and flags; all three are registered, so the outputs are glitch-safe.
//
//   state  | meaning
//   S_T0   | REM <- PC (start of fetch)
//   S_T1   | RDM <- mem[REM], PC <- PC+1
//   S_T2   | RI <- RDM
//   S_T3   | decode: finish 1-cycle ops, skip untaken branch, or REM <- PC for the operand
//   S_T4   | RDM <- operand; PC <- PC+1 for memory-reference ops
//   S_T5   | jumps: PC <- RDM; others: REM <- RDM
//   S_T6   | STA: RDM <- AC; others: RDM <- mem[REM]
//   S_T7   | STA: write memory; ALU ops: AC/NZ update
//   S_HALT | stopped until reset
module neander_ctrl #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input logic            clk,
  input logic            rst,
  neander_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state_q, state_d;
  logic   op_mem, op_jmp, op_undef, br_skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_T0;
    else     state_q <= state_d;
  end

  always_comb begin
    op_mem   = (bus.opcode >= OP_STA) && (bus.opcode <= OP_AND);
    op_jmp   = (bus.opcode == OP_JMP) || (bus.opcode == OP_JN) || (bus.opcode == OP_JZ);
    op_undef = (bus.opcode == 4'h7) || ((bus.opcode >= 4'hB) && (bus.opcode <= 4'hE));
    br_skip  = ((bus.opcode == OP_JN) && !bus.flag_n) || ((bus.opcode == OP_JZ) && !bus.flag_z);
  end

  always_comb begin
    state_d      = state_q;
    bus.rem_load = 1'b0;
    bus.rem_sel  = 1'b0;
    bus.rdm_load = 1'b0;
    bus.rdm_sel  = 1'b0;
    bus.ri_load  = 1'b0;
    bus.pc_load  = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.ac_load  = 1'b0;
    bus.nz_load  = 1'b0;
    bus.ula_sel  = 3'b000;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.halted   = 1'b0;
    case (state_q)
      S_T0: begin
        bus.rem_load = 1'b1;
        state_d      = S_T1;
      end
      S_T1: begin
        bus.mem_rd   = 1'b1;
        bus.rdm_load = 1'b1;
        bus.pc_load  = 1'b1;
        state_d      = S_T2;
      end
      S_T2: begin
        bus.ri_load = 1'b1;
        state_d     = S_T3;
      end
      S_T3: begin
        if ((bus.opcode == OP_HLT) || (op_undef && HALT_ON_UNDEF)) begin
          state_d = S_HALT;
        end else if (bus.opcode == OP_NOT) begin
          bus.ula_sel = 3'b011;
          bus.ac_load = 1'b1;
          bus.nz_load = 1'b1;
          state_d     = S_T0;
        end else if (op_mem || op_jmp) begin
          // An untaken branch still has to step the PC over its operand byte.
          if (br_skip) begin
            bus.pc_load = 1'b1;
            state_d     = S_T0;
          end else begin
            bus.rem_load = 1'b1;
            state_d      = S_T4;
          end
        end else begin
          state_d = S_T0;
        end
      end
      S_T4: begin
        bus.mem_rd   = 1'b1;
        bus.rdm_load = 1'b1;
        bus.pc_load  = op_mem;
        state_d      = S_T5;
      end
      S_T5: begin
        if (op_jmp) begin
          bus.pc_sel  = 1'b1;
          bus.pc_load = 1'b1;
          state_d     = S_T0;
        end else begin
          bus.rem_sel  = 1'b1;
          bus.rem_load = 1'b1;
          state_d      = S_T6;
        end
      end
      S_T6: begin
        bus.rdm_load = 1'b1;
        if (bus.opcode == OP_STA) bus.rdm_sel = 1'b1;
        else                      bus.mem_rd  = 1'b1;
        state_d = S_T7;
      end
      S_T7: begin
        if (bus.opcode == OP_STA) begin
          bus.mem_wr = 1'b1;
        end else if (op_mem) begin
          bus.ac_load = 1'b1;
          bus.nz_load = 1'b1;
          case (bus.opcode)
            OP_LDA:  bus.ula_sel = 3'b100;
            OP_OR:   bus.ula_sel = 3'b001;
            OP_AND:  bus.ula_sel = 3'b010;
            default: bus.ula_sel = 3'b000;
          endcase
        end
        state_d = S_T0;
      end
      S_HALT: begin
        bus.halted = 1'b1;
      end
      default: state_d = S_T0;
    endcase
    // Reset forces the state to T0 asynchronously; also silence T0's REM load so nothing moves while held.
    if (rst) begin
      bus.rem_load = 1'b0;
      bus.rem_sel  = 1'b0;
      bus.rdm_load = 1'b0;
      bus.rdm_sel  = 1'b0;
      bus.ri_load  = 1'b0;
      bus.pc_load  = 1'b0;
      bus.pc_sel   = 1'b0;
      bus.ac_load  = 1'b0;
      bus.nz_load  = 1'b0;
      bus.ula_sel  = 3'b000;
      bus.mem_rd   = 1'b0;
      bus.mem_wr   = 1'b0;
      bus.halted   = 1'b0;
    end
  end

endmodule

// File: tb/tb_neander_ctrl.sv
// Bench for neander_ctrl: a Neander datapath around the controller, an instruction-level reference model,
// a strobe-count vector table in direct-drive mode, and hand sequences for reset/halt corner cases.
module tb_neander_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neander_ctrl_if bus0 ();
  neander_ctrl_if bus1 ();
  neander_ctrl #(.HALT_ON_UNDEF(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  neander_ctrl #(.HALT_ON_UNDEF(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0] mem [256];
  logic [7:0] pc, rem, rdm, ri, ac, alu;
  logic       fn, fz;
  logic       drv_mode = 1'b0;
  logic [3:0] drv_op = 4'h0;
  logic       drv_n = 1'b0, drv_z = 1'b0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = 8'h00, prog_data = 8'h00;
  int         wr_in_rst = 0;

  assign bus0.opcode = drv_mode ? drv_op : ri[7:4];
  assign bus0.flag_n = drv_mode ? drv_n  : fn;
  assign bus0.flag_z = drv_mode ? drv_z  : fz;
  assign bus1.opcode = drv_op;
  assign bus1.flag_n = drv_n;
  assign bus1.flag_z = drv_z;

  logic [14:0] strb0;
  assign strb0 = {bus0.rem_load, bus0.rem_sel, bus0.rdm_load, bus0.rdm_sel, bus0.ri_load,
                  bus0.pc_load, bus0.pc_sel, bus0.ac_load, bus0.nz_load, bus0.ula_sel,
                  bus0.mem_rd, bus0.mem_wr, bus0.halted};
  logic [14:0] strb1;
  assign strb1 = {bus1.rem_load, bus1.rem_sel, bus1.rdm_load, bus1.rdm_sel, bus1.ri_load,
                  bus1.pc_load, bus1.pc_sel, bus1.ac_load, bus1.nz_load, bus1.ula_sel,
                  bus1.mem_rd, bus1.mem_wr, bus1.halted};

  always_comb begin
    alu = 8'h00;
    case (bus0.ula_sel)
      3'b000:  alu = ac + rdm;
      3'b001:  alu = ac | rdm;
      3'b010:  alu = ac & rdm;
      3'b011:  alu = ~ac;
      3'b100:  alu = rdm;
      default: alu = 8'h00;
    endcase
  end

  // Datapath model; memory is combinational-read, loaded by the bench only while reset is held.
  always @(posedge clk or posedge rst) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (rst) begin
      pc <= 8'h00; rem <= 8'h00; rdm <= 8'h00; ri <= 8'h00; ac <= 8'h00; fn <= 1'b0; fz <= 1'b0;
    end else begin
      if (bus0.rem_load) rem <= bus0.rem_sel ? rdm : pc;
      if (bus0.rdm_load) rdm <= bus0.rdm_sel ? ac : mem[rem];
      if (bus0.ri_load)  ri  <= rdm;
      if (bus0.pc_load)  pc  <= bus0.pc_sel ? rdm : pc + 8'd1;
      if (bus0.ac_load)  ac  <= alu;
      if (bus0.nz_load) begin fn <= alu[7]; fz <= (alu == 8'h00); end
      if (bus0.mem_wr && !drv_mode) mem[rem] <= rdm;
    end
  end

  always @(posedge clk) if (rst && (bus0.mem_wr || bus1.mem_wr)) wr_in_rst++;

  // Instruction-level reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_ac;
  bit         m_n, m_z;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(output int cyc, output bit hlt);
    logic [7:0] ins, opnd, val;
    ins  = m_mem[m_pc];
    opnd = m_mem[m_pc + 8'd1];
    hlt  = 1'b0;
    cyc  = 4;
    case (ins[7:4])
      4'h1: begin m_mem[opnd] = m_ac; m_pc = m_pc + 8'd2; cyc = 8; end
      4'h2, 4'h3, 4'h4, 4'h5: begin
        val = m_mem[opnd];
        case (ins[7:4])
          4'h2:    m_ac = val;
          4'h3:    m_ac = m_ac + val;
          4'h4:    m_ac = m_ac | val;
          default: m_ac = m_ac & val;
        endcase
        m_n = m_ac[7]; m_z = (m_ac == 8'h00);
        m_pc = m_pc + 8'd2; cyc = 8;
      end
      4'h6: begin m_ac = ~m_ac; m_n = m_ac[7]; m_z = (m_ac == 8'h00); m_pc = m_pc + 8'd1; end
      4'h8: begin m_pc = opnd; cyc = 6; end
      4'h9: if (m_n) begin m_pc = opnd; cyc = 6; end else m_pc = m_pc + 8'd2;
      4'hA: if (m_z) begin m_pc = opnd; cyc = 6; end else m_pc = m_pc + 8'd2;
      4'hF: begin hlt = 1'b1; m_pc = m_pc + 8'd1; end
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_pc = 8'h00; m_ac = 8'h00; m_n = 1'b0; m_z = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    prog_addr = a; prog_data = d; prog_we = 1'b1; m_mem[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Cycles from the current sample to the next RI load (T2) or HALT; -1 if neither within budget.
  task automatic wait_marker(output int cnt, output bit hlt);
    cnt = 0; hlt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      cnt++;
      if (bus0.halted) begin hlt = 1'b1; return; end
      if (bus0.ri_load) return;
    end
    cnt = -1;
  endtask

  task automatic run_program(input int max_instr);
    int cnt, cyc;
    bit h, hexp;
    @(negedge clk); rst = 1'b0; #1;
    wait_marker(cnt, h);
    chk("first_fetch_lat", cnt, 2);
    for (int i = 0; i < max_instr; i++) begin
      model_step(cyc, hexp);
      wait_marker(cnt, h);
      if (hexp) begin
        chk("halt_lat", cnt, 2);
        chk("halt_flag", 32'(h), 1);
        chk("halt_pc", 32'(pc), 32'(m_pc));
        break;
      end
      chk("instr_cycles", cnt, cyc);
      if (cnt != cyc) break;
      chk("pc", 32'(pc), 32'(m_pc + 8'd1));
      chk("ac", 32'(ac), 32'(m_ac));
      chk("flag_n", 32'(fn), 32'(m_n));
      chk("flag_z", 32'(fz), 32'(m_z));
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic       fn;
    logic       fz;
    int         cyc;   // 0 = HLT on the default instance
    int         pcl;
    int         pcj;
    int         wr;
    int         acl;
    logic [2:0] ula;
    bit         h1;    // halts on the HALT_ON_UNDEF=1 instance
  } vec_t;

  vec_t vecs[$];

  initial begin
    #3000000;
    $display("FAIL watchdog: run exceeded 3000000 time units");
    $fatal(1);
  end

  initial begin
    logic [14:0] s [21];
    bit          hs1 [21];
    int          ncyc, h0c, h1c, pcl, pcj, wr, acl, c, bad;
    logic [2:0]  ula_seen;
    vec_t        v;

    vecs.push_back(vec_t'{4'h0, 1'b0, 1'b0, 4, 1, 0, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h1, 1'b0, 1'b0, 8, 2, 0, 1, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h2, 1'b0, 1'b0, 8, 2, 0, 0, 1, 3'd4, 1'b0});
    vecs.push_back(vec_t'{4'h3, 1'b1, 1'b1, 8, 2, 0, 0, 1, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h4, 1'b0, 1'b0, 8, 2, 0, 0, 1, 3'd1, 1'b0});
    vecs.push_back(vec_t'{4'h5, 1'b0, 1'b1, 8, 2, 0, 0, 1, 3'd2, 1'b0});
    vecs.push_back(vec_t'{4'h6, 1'b0, 1'b0, 4, 1, 0, 0, 1, 3'd3, 1'b0});
    vecs.push_back(vec_t'{4'h7, 1'b0, 1'b0, 4, 1, 0, 0, 0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{4'h8, 1'b0, 1'b0, 6, 2, 1, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h9, 1'b0, 1'b0, 4, 2, 0, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h9, 1'b1, 1'b0, 6, 2, 1, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'h9, 1'b0, 1'b1, 4, 2, 0, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'hA, 1'b0, 1'b0, 4, 2, 0, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'hA, 1'b0, 1'b1, 6, 2, 1, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'hA, 1'b1, 1'b0, 4, 2, 0, 0, 0, 3'd0, 1'b0});
    vecs.push_back(vec_t'{4'hB, 1'b0, 1'b0, 4, 1, 0, 0, 0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{4'hC, 1'b1, 1'b1, 4, 1, 0, 0, 0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{4'hD, 1'b0, 1'b0, 4, 1, 0, 0, 0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{4'hE, 1'b0, 1'b0, 4, 1, 0, 0, 0, 3'd0, 1'b1});
    vecs.push_back(vec_t'{4'hF, 1'b0, 1'b0, 0, 0, 0, 0, 0, 3'd0, 1'b1});

    for (int a = 0; a < 256; a++) m_mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 256; a++) load(8'(a), 8'h00);
    chk("rst_quiet0", 32'(strb0), 0);
    chk("rst_quiet1", 32'(strb1), 0);

    // Strobe-count table, opcode and flags driven directly
    drv_mode = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_reset();
      drv_op = v.op; drv_n = v.fn; drv_z = v.fz;
      #1;
      chk("vec_rst_quiet", 32'({strb0, strb1}), 0);
      @(negedge clk); rst = 1'b0; #1;
      for (int k = 1; k <= 20; k++) begin
        if (k > 1) begin @(negedge clk); #1; end
        s[k] = strb0; hs1[k] = bus1.halted;
      end
      ncyc = -1; h0c = 0; h1c = 0;
      for (int k = 1; k <= 20; k++) begin
        if (ncyc < 0 && k > 3 && s[k][10]) ncyc = k - 3;
        if (h0c == 0 && s[k][0]) h0c = k;
        if (h1c == 0 && hs1[k]) h1c = k;
      end
      if (v.cyc > 0) begin
        pcl = 0; pcj = 0; wr = 0; acl = 0; ula_seen = 3'b111;
        for (int k = 1; k <= v.cyc; k++) begin
          pcl += int'(s[k][9]);
          pcj += int'(s[k][9] & s[k][8]);
          wr  += int'(s[k][1]);
          acl += int'(s[k][7]);
          if (s[k][7]) ula_seen = s[k][5:3];
        end
        chk($sformatf("vec%0d_cycles", i), ncyc, v.cyc);
        chk($sformatf("vec%0d_pc_loads", i), pcl, v.pcl);
        chk($sformatf("vec%0d_pc_jumps", i), pcj, v.pcj);
        chk($sformatf("vec%0d_mem_wr", i), wr, v.wr);
        chk($sformatf("vec%0d_ac_loads", i), acl, v.acl);
        if (v.acl > 0) chk($sformatf("vec%0d_ula", i), 32'(ula_seen), 32'(v.ula));
      end else begin
        chk($sformatf("vec%0d_halt0_cycle", i), h0c, 5);
      end
      chk($sformatf("vec%0d_halt1_cycle", i), h1c, v.h1 ? 5 : 0);
    end
    drv_mode = 1'b0;

    // NOP at 0x00: cycle-by-cycle strobes
    do_reset();
    load(8'h00, 8'h00);
    @(negedge clk); rst = 1'b0; #1;
    chk("nop_c1", 32'(strb0), 32'h4000);
    @(negedge clk); #1; chk("nop_c2", 32'(strb0), 32'h1204);
    @(negedge clk); #1; chk("nop_c3", 32'(strb0), 32'h0400);
    @(negedge clk); #1; chk("nop_c4", 32'(strb0), 32'h0000);
    @(negedge clk); #1; chk("nop_c5", 32'(strb0), 32'h4000);
    chk("nop_pc", 32'(pc), 32'h01);

    // LDA 0x80; ADD 0x81; STA 0x82; HLT
    do_reset();
    load(8'h00, 8'h20); load(8'h01, 8'h80); load(8'h02, 8'h30); load(8'h03, 8'h81);
    load(8'h04, 8'h10); load(8'h05, 8'h82); load(8'h06, 8'hF0);
    load(8'h80, 8'h05); load(8'h81, 8'h03); load(8'h82, 8'h00);
    @(negedge clk); rst = 1'b0; #1;
    c = 1;
    while (!bus0.halted && c < 60) begin @(negedge clk); #1; c++; end
    chk("prog_halt_cycle", c, 29);
    chk("prog_mem82", 32'(mem[8'h82]), 32'h08);
    chk("prog_pc", 32'(pc), 32'h07);
    chk("prog_ac", 32'(ac), 32'h08);
    m_mem[8'h82] = 8'h08;

    // HALT holds against any opcode/flag activity
    drv_mode = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drv_op = 4'($urandom); drv_n = 1'($urandom); drv_z = 1'($urandom);
      @(negedge clk); #1;
      chk("halt_hold", 32'(strb0), 32'h0001);
    end
    drv_mode = 1'b0;

    // Branches both ways, NOT, undefined-as-NOP, ending in HLT
    do_reset();
    load(8'h00, 8'h90); load(8'h01, 8'h20); load(8'h02, 8'hA0); load(8'h03, 8'h30);
    load(8'h04, 8'h60); load(8'h05, 8'h90); load(8'h06, 8'h20);
    load(8'h20, 8'hB0); load(8'h21, 8'h20); load(8'h22, 8'h40);
    load(8'h23, 8'hA0); load(8'h24, 8'h50); load(8'h40, 8'h00); load(8'h50, 8'hF0);
    run_program(20);
    chk("branch_prog_halted", 32'(bus0.halted), 1);

    // Reset arriving in T7 of STA must suppress the write
    do_reset();
    load(8'h00, 8'h10); load(8'h01, 8'h82); load(8'h82, 8'h5A);
    @(negedge clk); rst = 1'b0; #1;
    repeat (7) begin @(negedge clk); #1; end
    chk("sta_t7_reached", 32'(bus0.mem_wr), 1);
    #1 rst = 1'b1;
    #1 chk("abort_quiet", 32'(strb0), 0);
    repeat (3) begin @(negedge clk); #1; chk("abort_hold", 32'(strb0), 0); end
    chk("abort_mem82", 32'(mem[8'h82]), 32'h5A);
    @(negedge clk); rst = 1'b0; #1;
    chk("restart_c1", 32'(strb0), 32'h4000);
    @(negedge clk); #1; chk("restart_c2", 32'(strb0), 32'h1204);
    @(negedge clk); #1;
    chk("restart_pc", 32'(pc), 32'h01);
    chk("restart_rdm", 32'(rdm), 32'h10);

    // Random memory images executed against the instruction-level model
    for (int p = 0; p < 12; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) load(8'(a), 8'($urandom));
      run_program(40);
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== m_mem[a]) bad++;
      chk("rand_mem_image", bad, 0);
    end

    do_reset();
    chk("mem_wr_during_rst", wr_in_rst, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
